// File: rtl/imem_instr_encoder.sv
// imem_instr_encoder: accepts abstract instruction commands over a valid/ready
// stream, encodes each into a 32-bit RV32I word and writes the words
// sequentially into instruction memory, starting at word 0 of each session.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               begin a load session (honoured in IDLE or ERR only)
//   cmd_valid/cmd_ready command handshake; cmd_ready is a registered state decode
//   cmd_kind            0 R-type, 1 I-type ALU, 2 LW, 3 SW
//   cmd_alu             3-bit ALU control (same encoding as the decode side)
//   cmd_rd/rs1/rs2      register fields
//   cmd_imm             12-bit immediate
//   cmd_last            final command of the program
//   imem_we/addr/wdata  IMEM write port (one-cycle latency after accept)
//   busy                high when not in IDLE
//   done                one-cycle pulse on the final write
//   full                sticky: session ended at DEPTH without cmd_last
//   err_illegal         sticky: an illegal command was consumed
//   instr_count         words written this session
module imem_instr_encoder #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_kind,
  input  logic [2:0]        cmd_alu,
  input  logic [4:0]        cmd_rd,
  input  logic [4:0]        cmd_rs1,
  input  logic [4:0]        cmd_rs2,
  input  logic [11:0]       cmd_imm,
  input  logic              cmd_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic              err_illegal,
  output logic [ADDR_W:0]   instr_count
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  localparam logic [1:0] KIND_R  = 2'd0;
  localparam logic [1:0] KIND_I  = 2'd1;
  localparam logic [1:0] KIND_LW = 2'd2;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_d;
  logic                we_d, done_d, full_d, err_d, busy_d, ready_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [31:0]         wdata_d;

  logic [2:0]          f3;
  logic [6:0]          f7;
  logic [11:0]         imm_i;
  logic [31:0]         enc_word;
  logic                enc_illegal;

  // Command encoder: purely combinational from the command fields.
  always_comb begin
    f3          = 3'b000;
    f7          = 7'b0000000;
    imm_i       = cmd_imm;
    enc_word    = 32'h0;
    enc_illegal = 1'b0;

    case (cmd_alu)
      ALU_ADD: f3 = 3'b000;
      ALU_SUB: f3 = 3'b000;
      ALU_AND: f3 = 3'b111;
      ALU_OR:  f3 = 3'b110;
      ALU_SLT: f3 = 3'b010;
      ALU_XOR: f3 = 3'b100;
      ALU_SLL: f3 = 3'b001;
      ALU_SRL: f3 = 3'b101;
      default: f3 = 3'b000;
    endcase

    if (cmd_alu == ALU_SUB) begin
      f7 = 7'b0100000;
    end

    // Shift-immediates carry only a 5-bit shamt; upper bits are forced to zero.
    if ((cmd_alu == ALU_SLL) || (cmd_alu == ALU_SRL)) begin
      imm_i = {7'b0000000, cmd_imm[4:0]};
    end

    case (cmd_kind)
      KIND_R: begin
        enc_word = {f7, cmd_rs2, cmd_rs1, f3, cmd_rd, OP_R};
      end
      KIND_I: begin
        enc_word    = {imm_i, cmd_rs1, f3, cmd_rd, OP_I};
        enc_illegal = (cmd_alu == ALU_SUB);
      end
      KIND_LW: begin
        enc_word = {cmd_imm, cmd_rs1, 3'b010, cmd_rd, OP_LW};
      end
      default: begin
        enc_word = {cmd_imm[11:5], cmd_rs2, cmd_rs1, 3'b010, cmd_imm[4:0], OP_SW};
      end
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = instr_count;
    we_d    = 1'b0;
    addr_d  = imem_addr;
    wdata_d = imem_wdata;
    done_d  = 1'b0;
    full_d  = full;
    err_d   = err_illegal;

    case (state_q)
      S_IDLE, S_ERR: begin
        if (start) begin
          state_d = S_LOAD;
          ptr_d   = '0;
          cnt_d   = '0;
          full_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      S_LOAD: begin
        // cmd_ready is 1 throughout LOAD, so cmd_valid alone marks an accept.
        if (cmd_valid) begin
          if (enc_illegal) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end else begin
            we_d    = 1'b1;
            addr_d  = ptr_q;
            wdata_d = enc_word;
            ptr_d   = ptr_q + ADDR_W'(1);
            cnt_d   = instr_count + CNT_W'(1);
            if (cmd_last) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else if (ptr_q == ADDR_W'(DEPTH - 1)) begin
              full_d  = 1'b1;
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_LOAD);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      cmd_ready   <= 1'b0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= 32'h0;
      busy        <= 1'b0;
      done        <= 1'b0;
      full        <= 1'b0;
      err_illegal <= 1'b0;
      instr_count <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cmd_ready   <= ready_d;
      imem_we     <= we_d;
      imem_addr   <= addr_d;
      imem_wdata  <= wdata_d;
      busy        <= busy_d;
      done        <= done_d;
      full        <= full_d;
      err_illegal <= err_d;
      instr_count <= cnt_d;
    end
  end

endmodule

// File: doc/imem_instr_encoder.md
Name: imem_instr_encoder

Overview:
- Encoder side of the core's instruction decode path: accepts abstract instruction commands (kind, ALU op, registers, immediate) over a valid/ready stream, encodes them into 32-bit RV32I words and writes them sequentially into instruction memory.
- Sits between the bench/boot loader and the IMEM write port; loads programs for the 5-stage pipeline.
- The ALU-op field uses the same 3-bit ALU control encoding as the decode side, so encode followed by decode is an identity on supported instructions.

Parameters:
- ADDR_W, 6, IMEM word-address width.
- DEPTH, 64, number of IMEM words; must be ≤ 2^ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a load session; honoured only in IDLE or ERR.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  encoder accepts command.
- cmd_kind  input  2  0 R-type, 1 I-type ALU, 2 LW, 3 SW.
- cmd_alu  input  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 100 slt, 101 xor, 110 sll, 111 srl.
- cmd_rd  input  5  destination register.
- cmd_rs1  input  5  source register 1.
- cmd_rs2  input  5  source register 2.
- cmd_imm  input  12  immediate.
- cmd_last  input  1  marks the final command of the program.
- imem_we  output  1  IMEM write strobe.
- imem_addr  output  ADDR_W  IMEM word address.
- imem_wdata  output  32  encoded instruction.
- busy  output  1  high when not in IDLE.
- done  output  1  one-cycle pulse when the load completes.
- full  output  1  sticky: load terminated at DEPTH without cmd_last.
- err_illegal  output  1  sticky: illegal command received.
- instr_count  output  ADDR_W+1  number of words written this session.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; write pointer 0.
- FSM states: IDLE, LOAD, DONE, ERR.
  - IDLE: start → LOAD; clears pointer, instr_count, full and err_illegal.
  - LOAD: cmd_ready = 1, decoded from the registered state only (no combinational path from cmd_valid).
- Handshake in LOAD:
  - A command is accepted at a rising edge where cmd_valid & cmd_ready.
  - Next cycle: imem_we=1, imem_addr=pointer, imem_wdata=encoded word (latency 1).
  - Pointer and instr_count increment with that write.
  - Throughput is one command per cycle; cmd_valid low produces no write.
- imem_we is a single-cycle strobe per accepted command. imem_addr and imem_wdata hold their last values when imem_we=0.
- Encoding by cmd_kind (f3 = funct3: add/sub 000, sll 001, slt 010, xor 100, srl 101, or 110, and 111):
  - R-type: {f7, rs2, rs1, f3, rd, 0110011}; f7 = 0100000 for sub, otherwise 0000000.
  - I-type: {imm, rs1, f3, rd, 0010011}. For sll/srl, imm is forced to {7'b0, cmd_imm[4:0]}. cmd_alu=sub is illegal.
  - LW: {imm, rs1, 010, rd, 0000011}; cmd_alu ignored.
  - SW: {imm[11:5], rs2, rs1, 010, imm[4:0], 0100011}; cmd_alu ignored.
- Accept with cmd_last=1: the write occurs as normal; next state DONE. cmd_ready is therefore 0 the cycle after the accept.
- Accept at pointer = DEPTH-1 without cmd_last: the write occurs; full set; next state DONE.
- Accept at pointer = DEPTH-1 with cmd_last: the write occurs; full stays 0.
- DONE: done=1 for exactly one cycle (the write-strobe cycle); then → IDLE.
- Illegal command: consumed (cmd_ready was 1); no IMEM write; err_illegal set; next state ERR.
- ERR: cmd_ready=0, no done. start → LOAD, clearing the flags.
- start asserted in LOAD or DONE is ignored.
- Asserting rst_n low mid-load aborts immediately; IMEM contents already written are not undone.

Test Plan:
- Reset, start, then ADD x3,x1,x2 (kind0, alu000, last=1) → next cycle: imem_we=1, addr 0, wdata 0x002081B3, done=1, instr_count 1; following cycle busy=0.
- Back-to-back burst with cmd_valid held high: SUB x3,x1,x2; ADDI x5,x0,-1 (imm 0xFFF); LW x6,8(x2); SW x6,12(x2) (last) → consecutive writes at addr 0..3 with data 0x402081B3, 0xFFF00293, 0x00812303, 0x00612623; done on the 4th write.
- SRLI x7,x1,3 sent with imm 0xFE3 → wdata 0x0030D393 (upper immediate bits forced to zero).
- I-type with cmd_alu=001 → no imem_we, err_illegal=1, state ERR, cmd_ready=0; then start → flags cleared, LOAD.
- DEPTH=4, stream 6 commands with no last → 4 writes (addr 0..3), full=1, done pulse, cmd_ready low; commands 5–6 are never accepted.
- Pull rst_n low mid-burst → all outputs 0 asynchronously; after release: IDLE, cmd_ready=0 until start.
